// File: rtl/qif_tick_scheduler_pkg.sv
// Shared types, defaults and the saturating helper for the QIF tick scheduler.
package qif_pkg;

    typedef logic signed [7:0]  vmem_t;
    typedef logic signed [10:0] acc_t;

    localparam vmem_t V_TH_DEFAULT    = 8'sd50;
    localparam vmem_t V_RESET_DEFAULT = -8'sd20;

    typedef enum logic [2:0] {
        IDLE,
        FETCH,
        UPDATE,
        EMIT,
        DONE
    } sched_state_t;

    // Clamp an 11-bit signed sum into the 8-bit membrane range.
    function automatic vmem_t sat8(input acc_t x);
        if (x > 11'sd127) begin
            return 8'sd127;
        end else if (x < -11'sd128) begin
            return -8'sd128;
        end else begin
            return vmem_t'(x[7:0]);
        end
    endfunction

endpackage

// File: rtl/qif_tick_scheduler_update_core.sv
// qif_update_core: combinational single-neuron QIF step (threshold/reset or
// saturating quadratic integrate). Refractory ports exist only when
// QIF_SCHED_REFRACTORY_EN is defined.
module qif_update_core
    import qif_pkg::*;
#(
    parameter vmem_t V_TH    = V_TH_DEFAULT,
    parameter vmem_t V_RESET = V_RESET_DEFAULT
`ifdef QIF_SCHED_REFRACTORY_EN
    , parameter logic [1:0] REFRACT_CYC = 2'd2
`endif
) (
    input  logic signed [7:0] v,
    input  logic signed [7:0] i_syn,
`ifdef QIF_SCHED_REFRACTORY_EN
    input  logic [1:0]        refr,
    output logic [1:0]        refr_next,
`endif
    output logic signed [7:0] v_next,
    output logic              spike
);

    acc_t v_x;
    acc_t vs_x;
    acc_t i_x;
    acc_t sum;

    // Threshold test first; otherwise V + (V>>>3)^2 + (I>>>2), saturated.
    always_comb begin
        v_x    = acc_t'(v);
        vs_x   = acc_t'(v >>> 3);
        i_x    = acc_t'(i_syn >>> 2);
        sum    = v_x + vs_x * vs_x + i_x;
        v_next = sat8(sum);
        spike  = 1'b0;
`ifdef QIF_SCHED_REFRACTORY_EN
        refr_next = '0;
        if (refr != 2'd0) begin
            v_next    = V_RESET;
            refr_next = refr - 2'd1;
        end else if (v >= V_TH) begin
            v_next    = V_RESET;
            spike     = 1'b1;
            refr_next = REFRACT_CYC;
        end
`else
        if (v >= V_TH) begin
            v_next = V_RESET;
            spike  = 1'b1;
        end
`endif
    end

endmodule

// File: rtl/qif_tick_scheduler.sv
// qif_tick_scheduler: sweeps one QIF update core across N_NEURONS virtual
// neurons per tick, fetching I_syn per neuron and emitting spike events on a
// valid/ready stream. Optional per-neuron refractory counters are enabled by
// the macro QIF_SCHED_REFRACTORY_EN. rst_n is a synchronous active-high reset.
module qif_tick_scheduler
    import qif_pkg::*;
#(
    parameter int unsigned      N_NEURONS = 16,
    parameter int unsigned      IDX_W     = $clog2(N_NEURONS),
    parameter logic signed [7:0] V_TH     = V_TH_DEFAULT,
    parameter logic signed [7:0] V_RESET  = V_RESET_DEFAULT
`ifdef QIF_SCHED_REFRACTORY_EN
    , parameter int unsigned    REFRACT_CYC = 2
`endif
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic                    tick_start,
    output logic                    busy,
    output logic                    tick_done,
    output logic                    isyn_req,
    output logic [IDX_W-1:0]        isyn_idx,
    input  logic                    isyn_valid,
    input  logic signed [7:0]       isyn_data,
    output logic                    spike_valid,
    output logic [IDX_W-1:0]        spike_idx,
    input  logic                    spike_ready,
    input  logic [IDX_W-1:0]        rd_idx,
    output logic signed [7:0]       rd_vmem
);

    sched_state_t     state;
    sched_state_t     state_next;
    logic [IDX_W-1:0] idx;
    logic [IDX_W-1:0] idx_next;
    logic             last;
    logic             upd_en;
    vmem_t            isyn_q;
    vmem_t            vmem [N_NEURONS];
    vmem_t            v_next;
    logic             spike;
`ifdef QIF_SCHED_REFRACTORY_EN
    logic [1:0]       refr [N_NEURONS];
    logic [1:0]       refr_next;
`endif

    assign last      = (idx == IDX_W'(N_NEURONS - 1));
    assign isyn_idx  = idx;
    assign spike_idx = idx;

    qif_update_core #(
        .V_TH        (V_TH),
        .V_RESET     (V_RESET)
`ifdef QIF_SCHED_REFRACTORY_EN
        , .REFRACT_CYC (2'(REFRACT_CYC))
`endif
    ) u_core (
        .v         (vmem[idx]),
        .i_syn     (isyn_q),
`ifdef QIF_SCHED_REFRACTORY_EN
        .refr      (refr[idx]),
        .refr_next (refr_next),
`endif
        .v_next    (v_next),
        .spike     (spike)
    );

    // FSM state and neuron index register.
    always_ff @(posedge clk) begin
        if (rst_n) begin
            state <= IDLE;
            idx   <= '0;
        end else begin
            state <= state_next;
            idx   <= idx_next;
        end
    end

    // Next-state, index advance and handshake outputs.
    always_comb begin
        state_next  = state;
        idx_next    = idx;
        upd_en      = 1'b0;
        busy        = 1'b1;
        tick_done   = 1'b0;
        isyn_req    = 1'b0;
        spike_valid = 1'b0;
        case (state)
            IDLE: begin
                busy = 1'b0;
                if (tick_start) begin
                    state_next = FETCH;
                    idx_next   = '0;
                end
            end
            FETCH: begin
                isyn_req = 1'b1;
                if (isyn_valid) begin
                    state_next = UPDATE;
                end
            end
            UPDATE: begin
                upd_en = 1'b1;
                if (spike) begin
                    state_next = EMIT;
                end else if (last) begin
                    state_next = DONE;
                end else begin
                    idx_next   = idx + IDX_W'(1);
                    state_next = FETCH;
                end
            end
            EMIT: begin
                spike_valid = 1'b1;
                if (spike_ready) begin
                    if (last) begin
                        state_next = DONE;
                    end else begin
                        idx_next   = idx + IDX_W'(1);
                        state_next = FETCH;
                    end
                end
            end
            DONE: begin
                tick_done  = 1'b1;
                state_next = IDLE;
            end
            default: state_next = IDLE;
        endcase
    end

    // I_syn capture and state-array write-back.
    always_ff @(posedge clk) begin
        if (rst_n) begin
            isyn_q <= '0;
            for (int unsigned n = 0; n < N_NEURONS; n++) begin
                vmem[n] <= V_RESET;
`ifdef QIF_SCHED_REFRACTORY_EN
                refr[n] <= '0;
`endif
            end
        end else begin
            if (state == FETCH && isyn_valid) begin
                isyn_q <= isyn_data;
            end
            if (upd_en) begin
                vmem[idx] <= v_next;
`ifdef QIF_SCHED_REFRACTORY_EN
                refr[idx] <= refr_next;
`endif
            end
        end
    end

    // Debug read port; out-of-range addresses read as zero.
    always_comb begin
        rd_vmem = '0;
        if (32'(rd_idx) < N_NEURONS) begin
            rd_vmem = vmem[rd_idx];
        end
    end

endmodule

// File: tb/tb_qif_tick_scheduler.sv
// Testbench for qif_tick_scheduler (default build): table of tick vectors plus
// directed sequences for backpressure, dropped tick_start and mid-sweep reset.
// A second small instance with a high threshold exercises positive saturation.
module tb_qif_tick_scheduler;

    logic              clk;
    logic              rst_n;
    logic              tick_start;
    logic              isyn_valid;
    logic signed [7:0] isyn_data;
    logic              spike_ready;

    logic              busy, tick_done, isyn_req, spike_valid;
    logic [1:0]        isyn_idx, spike_idx, rd_idx;
    logic signed [7:0] rd_vmem;

    logic              busy2, tick_done2, isyn_req2, spike_valid2;
    logic [0:0]        isyn_idx2, spike_idx2, rd_idx2;
    logic signed [7:0] rd_vmem2;

    int passed = 0;
    int total  = 0;

    qif_tick_scheduler #(
        .N_NEURONS (4)
    ) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .tick_start  (tick_start),
        .busy        (busy),
        .tick_done   (tick_done),
        .isyn_req    (isyn_req),
        .isyn_idx    (isyn_idx),
        .isyn_valid  (isyn_valid),
        .isyn_data   (isyn_data),
        .spike_valid (spike_valid),
        .spike_idx   (spike_idx),
        .spike_ready (spike_ready),
        .rd_idx      (rd_idx),
        .rd_vmem     (rd_vmem)
    );

    qif_tick_scheduler #(
        .N_NEURONS (2),
        .V_TH      (8'sd127),
        .V_RESET   (8'sd100)
    ) dut_sat (
        .clk         (clk),
        .rst_n       (rst_n),
        .tick_start  (tick_start),
        .busy        (busy2),
        .tick_done   (tick_done2),
        .isyn_req    (isyn_req2),
        .isyn_idx    (isyn_idx2),
        .isyn_valid  (isyn_valid),
        .isyn_data   (isyn_data),
        .spike_valid (spike_valid2),
        .spike_idx   (spike_idx2),
        .spike_ready (spike_ready),
        .rd_idx      (rd_idx2),
        .rd_vmem     (rd_vmem2)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    typedef struct {
        logic do_rst;
        int   isyn;
        int   exp_v;
        int   exp_spikes;
        int   exp_cycles;
        int   exp_v2;
    } vec_t;

    vec_t vecs[6];

    task automatic check(input string name, input int actual, input int expected);
        total++;
        if (actual == expected) passed++;
        else $display("FAIL %s: got %0d expected %0d", name, actual, expected);
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst_n = 1'b1;
        repeat (2) @(negedge clk);
        rst_n = 1'b0;
    endtask

    task automatic check_all_v(input string tag, input int exp);
        for (int n = 0; n < 4; n++) begin
            rd_idx = 2'(n);
            #1;
            check($sformatf("%s_v%0d", tag, n), rd_vmem, exp);
        end
    endtask

    // Start one sweep and wait (bounded) for tick_done, checking spike order.
    task automatic run_tick(output int cycles, output int spikes);
        int seen;
        seen   = 0;
        spikes = 0;
        cycles = 0;
        @(negedge clk);
        tick_start = 1'b1;
        @(posedge clk);
        #1 tick_start = 1'b0;
        while (seen == 0 && cycles < 100) begin
            @(posedge clk);
            cycles++;
            @(negedge clk);
            if (spike_valid && spike_ready) begin
                check("spike_order", int'(spike_idx), spikes);
                spikes++;
            end
            if (tick_done) seen = 1;
        end
        check("tick_done_seen", seen, 1);
    endtask

    initial begin
        int cyc, spk, seen, w, dones;

        rst_n       = 1'b0;
        tick_start  = 1'b0;
        isyn_valid  = 1'b1;
        isyn_data   = '0;
        spike_ready = 1'b1;
        rd_idx      = '0;
        rd_idx2     = '0;

        // Reset state
        do_reset();
        #1;
        check("rst_busy", busy, 0);
        check("rst_tick_done", tick_done, 0);
        check("rst_spike_valid", spike_valid, 0);
        check("rst_isyn_req", isyn_req, 0);
        check("rst_isyn_idx", int'(isyn_idx), 0);
        check("rst_spike_idx", int'(spike_idx), 0);
        check_all_v("rst", -20);
        rd_idx2 = 1'b0;
        #1;
        check("rst_sat_v0", rd_vmem2, 100);

        // {rst, I_syn, V after, spikes, cycles to tick_done, saturating-instance V}
        vecs[0] = '{1'b1,    8,  -9, 0,  8, 127};
        vecs[1] = '{1'b1,  127,  20, 0,  8, 127};
        vecs[2] = '{1'b0,  127,  55, 0,  8, 100};
        vecs[3] = '{1'b0,  127, -20, 4, 12, 127};
        vecs[4] = '{1'b0, -128, -43, 0,  8, 100};
        vecs[5] = '{1'b0, -128, -39, 0,  8, 127};

        for (int k = 0; k < 6; k++) begin
            if (vecs[k].do_rst) do_reset();
            isyn_data = 8'(vecs[k].isyn);
            run_tick(cyc, spk);
            check($sformatf("vec%0d_cycles", k), cyc, vecs[k].exp_cycles);
            check($sformatf("vec%0d_spikes", k), spk, vecs[k].exp_spikes);
            check_all_v($sformatf("vec%0d", k), vecs[k].exp_v);
            for (int n = 0; n < 2; n++) begin
                rd_idx2 = 1'(n);
                #1;
                check($sformatf("vec%0d_sat_v%0d", k, n), rd_vmem2, vecs[k].exp_v2);
            end
        end

        // Backpressure on the first spike of tick 3
        do_reset();
        isyn_data = 8'sd127;
        run_tick(cyc, spk);
        run_tick(cyc, spk);
        spike_ready = 1'b0;
        @(negedge clk);
        tick_start = 1'b1;
        @(posedge clk);
        #1 tick_start = 1'b0;
        w = 0;
        while (!spike_valid && w < 20) begin
            @(negedge clk);
            w++;
        end
        check("bp_valid_seen", spike_valid, 1);
        for (int c = 0; c < 5; c++) begin
            @(negedge clk);
            check($sformatf("bp_hold_valid_%0d", c), spike_valid, 1);
            check($sformatf("bp_hold_idx_%0d", c), int'(spike_idx), 0);
            check($sformatf("bp_hold_req_%0d", c), isyn_req, 0);
            check($sformatf("bp_hold_busy_%0d", c), busy, 1);
        end
        spike_ready = 1'b1;
        spk  = 0;
        seen = 0;
        cyc  = 0;
        while (seen == 0 && cyc < 100) begin
            if (spike_valid && spike_ready) begin
                check("bp_spike_order", int'(spike_idx), spk);
                spk++;
            end
            if (tick_done) seen = 1;
            else begin
                @(negedge clk);
                cyc++;
            end
        end
        check("bp_done_seen", seen, 1);
        check("bp_spikes", spk, 4);
        check_all_v("bp", -20);
        @(negedge clk);
        check("bp_idle_busy", busy, 0);

        // tick_start while busy is dropped
        do_reset();
        isyn_data = 8'sd8;
        @(negedge clk);
        tick_start = 1'b1;
        @(negedge clk);
        tick_start = 1'b0;
        dones = 0;
        repeat (3) begin
            @(negedge clk);
            if (tick_done) dones++;
        end
        check("drop_busy", busy, 1);
        tick_start = 1'b1;
        @(negedge clk);
        tick_start = 1'b0;
        if (tick_done) dones++;
        repeat (30) begin
            @(negedge clk);
            if (tick_done) dones++;
        end
        check("drop_done_count", dones, 1);
        check_all_v("drop", -9);

        // Reset while holding in FETCH
        isyn_valid = 1'b0;
        @(negedge clk);
        tick_start = 1'b1;
        @(negedge clk);
        tick_start = 1'b0;
        repeat (2) @(negedge clk);
        check("fetch_hold_req", isyn_req, 1);
        check("fetch_hold_idx", int'(isyn_idx), 0);
        check("fetch_hold_busy", busy, 1);
        rst_n = 1'b1;
        @(negedge clk);
        rst_n = 1'b0;
        check("mid_rst_busy", busy, 0);
        check("mid_rst_req", isyn_req, 0);
        check_all_v("mid_rst", -20);
        isyn_valid = 1'b1;
        dones = 0;
        repeat (12) begin
            @(negedge clk);
            if (tick_done) dones++;
        end
        check("mid_rst_no_done", dones, 0);
        check("mid_rst_idle", busy, 0);

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
